// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller for the 32-bit ripple ALU cell array
// Sequences one op at a time: single EXEC pass for logic/arith, bit-serial shifts.
module alu_sequencer (
   input  logic        Clk,
   input  logic        ResetN,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [3:0]  ReqOp,
   input  logic [31:0] ReqA,
   input  logic [31:0] ReqB,
   output logic        RespValid,
   input  logic        RespReady,
   output logic [31:0] RespData,
   output logic [31:0] AluA,
   output logic [31:0] AluB,
   output logic        AluInvertA,
   output logic        AluInvertB,
   output logic        AluCarryIn,
   output logic        AluOr,
   output logic        AluFlood,
   input  logic [31:0] AluResult,
   input  logic        AluCarryOut
);

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   state_t      state;
   logic [3:0]  op;
   logic [31:0] shiftReg;
   logic [4:0]  count;

   assign ReqReady = (state == IDLE);

   // Control vector {InvertA, InvertB, CarryIn, Or, Flood} for the array pass.
   function automatic logic [4:0] ctrlFor(input logic [3:0] o);
      case (o)
         OP_SUB, OP_SLT, OP_SLTU: ctrlFor = 5'b01100;
         OP_AND:                  ctrlFor = 5'b11011;
         OP_OR:                   ctrlFor = 5'b00010;
         OP_XOR:                  ctrlFor = 5'b01001;
         default:                 ctrlFor = 5'b00000;
      endcase
   endfunction

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state     <= IDLE;
         op        <= 4'd0;
         shiftReg  <= 32'd0;
         count     <= 5'd0;
         RespValid <= 1'b0;
         RespData  <= 32'd0;
         AluA      <= 32'd0;
         AluB      <= 32'd0;
         {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood} <= 5'b00000;
      end else begin
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  AluA <= ReqA;
                  AluB <= ReqB;
                  op   <= ReqOp;
                  if (ReqOp inside {OP_SLL, OP_SRL, OP_SRA}) begin
                     shiftReg <= ReqA;
                     count    <= ReqB[4:0];
                     state    <= SHIFT;
                  end else begin
                     {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood} <= ctrlFor(ReqOp);
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: RespData <= AluResult;
                  OP_SLTU: RespData <= {31'd0, ~AluCarryOut};
                  // Signs differ: A is less exactly when A is negative; otherwise trust the difference sign.
                  OP_SLT:  RespData <= {31'd0, (AluA[31] ^ AluB[31]) ? AluA[31] : AluResult[31]};
                  default: RespData <= 32'd0;
               endcase
               {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood} <= 5'b00000;
               RespValid <= 1'b1;
               state     <= DONE;
            end
            SHIFT: begin
               if (count != 5'd0) begin
                  case (op)
                     OP_SLL:  shiftReg <= {shiftReg[30:0], 1'b0};
                     OP_SRA:  shiftReg <= {shiftReg[31], shiftReg[31:1]};
                     default: shiftReg <= {1'b0, shiftReg[31:1]};
                  endcase
                  count <= count - 5'd1;
               end else begin
                  RespData  <= shiftReg;
                  RespValid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (RespReady) begin
                  RespValid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
// Includes a behavioural model of the ripple ALU cell array driving AluResult.
module tb_alu_sequencer;

   logic        Clk = 1'b0;
   logic        ResetN = 1'b0;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic [3:0]  ReqOp = 4'd0;
   logic [31:0] ReqA = 32'd0;
   logic [31:0] ReqB = 32'd0;
   logic        RespValid;
   logic        RespReady = 1'b0;
   logic [31:0] RespData;
   logic [31:0] AluA, AluB;
   logic        AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood;
   logic [31:0] AluResult;
   logic        AluCarryOut;

   int total = 0;
   int bad = 0;

   logic [4:0]  execCtrl;
   int          lastCycles;
   logic [31:0] lastData;
   logic        lastTimeout;

   always #5 Clk = ~Clk;

   alu_sequencer dut (
      .Clk(Clk), .ResetN(ResetN),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
      .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
      .AluA(AluA), .AluB(AluB),
      .AluInvertA(AluInvertA), .AluInvertB(AluInvertB), .AluCarryIn(AluCarryIn),
      .AluOr(AluOr), .AluFlood(AluFlood),
      .AluResult(AluResult), .AluCarryOut(AluCarryOut)
   );

   // Cell array: optional operand inversion, then OR plane or ripple adder; Flood forces every carry-in high.
   logic [31:0] mA, mB;
   logic [32:0] mSum;
   always_comb begin
      mA = AluA ^ {32{AluInvertA}};
      mB = AluB ^ {32{AluInvertB}};
      mSum = 33'd0;
      AluResult = 32'd0;
      AluCarryOut = 1'b0;
      if (AluOr) begin
         AluResult = (mA | mB) ^ {32{AluFlood}};
      end else if (AluFlood) begin
         AluResult = ~(mA ^ mB);
      end else begin
         mSum = {1'b0, mA} + {1'b0, mB} + {32'd0, AluCarryIn};
         AluResult = mSum[31:0];
         AluCarryOut = mSum[32];
      end
   end

   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b;
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      lastCycles = 1;
      execCtrl = {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood};
      while (!RespValid && lastCycles < 100) begin
         @(posedge Clk); #1;
         lastCycles++;
      end
      lastTimeout = !RespValid;
      lastData = RespData;
      RespReady = 1'b1;
      @(posedge Clk); #1;
      RespReady = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (ReqReady !== 1'b1 || RespValid !== 1'b0 || RespData !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: ReqReady=%b RespValid=%b RespData=%h, required 1 0 00000000", ReqReady, RespValid, RespData);
      end
      total++;
      if (AluA !== 32'd0 || AluB !== 32'd0 || {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood} !== 5'b0) begin
         bad++;
         $display("FAIL reset_alu: AluA=%h AluB=%h ctrl=%b, required 0 0 00000", AluA, AluB,
                  {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood});
      end
      @(negedge Clk);
      ResetN = 1'b1;
   endtask

   task automatic test_add_sub();
      runOp(4'd0, 32'hFFFFFFFF, 32'd1);
      total++;
      if (lastTimeout || lastData !== 32'h0 || lastCycles != 2 || execCtrl !== 5'b00000) begin
         bad++;
         $display("FAIL add: data=%h cycles=%0d ctrl=%b, required 00000000 2 00000", lastData, lastCycles, execCtrl);
      end
      runOp(4'd1, 32'd5, 32'd7);
      total++;
      if (lastTimeout || lastData !== 32'hFFFFFFFE || lastCycles != 2 || execCtrl !== 5'b01100) begin
         bad++;
         $display("FAIL sub: data=%h cycles=%0d ctrl=%b, required fffffffe 2 01100", lastData, lastCycles, execCtrl);
      end
      #1;
      total++;
      if ({AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood} !== 5'b0) begin
         bad++;
         $display("FAIL ctrl_idle: ctrl=%b, required 00000", {AluInvertA, AluInvertB, AluCarryIn, AluOr, AluFlood});
      end
   endtask

   task automatic test_logic();
      logic [3:0]  ops [3]  = '{4'd2, 4'd3, 4'd4};
      logic [31:0] exps [3] = '{32'h00F0A500, 32'hFFF0FFA5, 32'hFF005AA5};
      logic [4:0]  ctrls [3] = '{5'b11011, 5'b00010, 5'b01001};
      for (int i = 0; i < 3; i++) begin
         runOp(ops[i], 32'hF0F0A5A5, 32'h0FF0FF00);
         total++;
         if (lastTimeout || lastData !== exps[i] || execCtrl !== ctrls[i]) begin
            bad++;
            $display("FAIL logic_op%0d: data=%h ctrl=%b, required %h %b", ops[i], lastData, execCtrl, exps[i], ctrls[i]);
         end
      end
   endtask

   task automatic test_compare();
      logic [3:0]  ops [4]  = '{4'd5, 4'd6, 4'd5, 4'd6};
      logic [31:0] as [4]   = '{32'h80000000, 32'h80000000, 32'd5, 32'd0};
      logic [31:0] bs [4]   = '{32'd1, 32'd1, 32'd5, 32'd1};
      logic [31:0] exps [4] = '{32'd1, 32'd0, 32'd0, 32'd1};
      for (int i = 0; i < 4; i++) begin
         runOp(ops[i], as[i], bs[i]);
         total++;
         if (lastTimeout || lastData !== exps[i] || execCtrl !== 5'b01100) begin
            bad++;
            $display("FAIL compare_%0d: data=%h ctrl=%b, required %h 01100", i, lastData, execCtrl, exps[i]);
         end
      end
   endtask

   task automatic test_shift();
      logic [3:0]  ops [3]  = '{4'd9, 4'd7, 4'd8};
      logic [31:0] as [3]   = '{32'h80000010, 32'h12345678, 32'h80000000};
      logic [31:0] bs [3]   = '{32'd4, 32'hFFFFFFE0, 32'd31};
      logic [31:0] exps [3] = '{32'hF8000001, 32'h12345678, 32'h00000001};
      int          cyc [3]  = '{6, 2, 33};
      for (int i = 0; i < 3; i++) begin
         runOp(ops[i], as[i], bs[i]);
         total++;
         if (lastTimeout || lastData !== exps[i] || lastCycles != cyc[i] || execCtrl !== 5'b0) begin
            bad++;
            $display("FAIL shift_%0d: data=%h cycles=%0d ctrl=%b, required %h %0d 00000", i, lastData, lastCycles,
                     execCtrl, exps[i], cyc[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int errs = 0;
      int waitCyc = 0;
      @(negedge Clk);
      ReqValid = 1'b1; ReqOp = 4'd0; ReqA = 32'd1; ReqB = 32'd2;
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      while (!RespValid && waitCyc < 100) begin
         @(posedge Clk); #1;
         waitCyc++;
      end
      ReqValid = 1'b1; ReqOp = 4'd1; ReqA = 32'd100; ReqB = 32'd50;
      for (int i = 0; i < 10; i++) begin
         if (RespValid !== 1'b1 || RespData !== 32'd3 || ReqReady !== 1'b0) errs++;
         @(posedge Clk); #1;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL backpressure_hold: %0d bad cycles, required 0", errs);
      end
      total++;
      if (AluA !== 32'd1 || AluB !== 32'd2) begin
         bad++;
         $display("FAIL backpressure_ignore: AluA=%h AluB=%h, required 00000001 00000002", AluA, AluB);
      end
      ReqValid = 1'b0;
      RespReady = 1'b1;
      @(posedge Clk); #1;
      RespReady = 1'b0;
      total++;
      if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
         bad++;
         $display("FAIL backpressure_release: ReqReady=%b RespValid=%b, required 1 0", ReqReady, RespValid);
      end
   endtask

   task automatic test_illegal();
      runOp(4'd12, 32'h5, 32'h3);
      total++;
      if (lastTimeout || lastData !== 32'd0 || lastCycles != 2 || execCtrl !== 5'b0) begin
         bad++;
         $display("FAIL illegal: data=%h cycles=%0d ctrl=%b, required 00000000 2 00000", lastData, lastCycles, execCtrl);
      end
   endtask

   task automatic test_reset_mid_shift();
      int seen = 0;
      @(negedge Clk);
      ReqValid = 1'b1; ReqOp = 4'd7; ReqA = 32'h1; ReqB = 32'd20;
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      ResetN = 1'b0;
      #1;
      total++;
      if (RespValid !== 1'b0 || ReqReady !== 1'b1 || AluA !== 32'd0 || RespData !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_shift: RespValid=%b ReqReady=%b AluA=%h RespData=%h, required 0 1 0 0",
                  RespValid, ReqReady, AluA, RespData);
      end
      @(negedge Clk);
      ResetN = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge Clk); #1;
         if (RespValid) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL reset_no_resp: RespValid seen %0d cycles, required 0", seen);
      end
      runOp(4'd0, 32'd2, 32'd3);
      total++;
      if (lastTimeout || lastData !== 32'd5 || lastCycles != 2) begin
         bad++;
         $display("FAIL post_reset_add: data=%h cycles=%0d, required 00000005 2", lastData, lastCycles);
      end
   endtask

   task automatic test_back_to_back();
      runOp(4'd0, 32'd10, 32'd20);
      total++;
      if (lastTimeout || lastData !== 32'd30) begin
         bad++;
         $display("FAIL b2b_first: data=%h, required 0000001e", lastData);
      end
      runOp(4'd8, 32'hF0000000, 32'd4);
      total++;
      if (lastTimeout || lastData !== 32'h0F000000 || lastCycles != 6) begin
         bad++;
         $display("FAIL b2b_second: data=%h cycles=%0d, required 0f000000 6", lastData, lastCycles);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_compare();
      test_shift();
      test_backpressure();
      test_illegal();
      test_reset_mid_shift();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
